// File: rtl/dma_rd_stage.sv
// dma_rd_stage: one SRAM read per accepted address, read data tagged and buffered in a credit-protected FIFO.
// Optional macro DMA_RD_STAT_EN adds beat_cnt/frame_cnt statistics outputs.
module dma_rd_stage #(
  parameter int AW    = 14,
  parameter int DW    = 32,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a_addr,
  input  logic          a_first,
  input  logic          a_last,
  input  logic          a_valid,
  output logic          a_ready,
  output logic          mem_cs,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] m_data,
  output logic          m_first,
  output logic          m_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          idle
`ifdef DMA_RD_STAT_EN
  ,
  output logic [15:0]   beat_cnt,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CntMax = CW'(DEPTH);
  localparam logic [CW-1:0] One    = CW'(1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  wrPtr_q, wrPtr_d;
  logic [CW-1:0]  rdPtr_q, rdPtr_d;
  logic [LAT-1:0] tagValid_q, tagFirst_q, tagLast_q;
  logic [DW+1:0]  fifoMem_q [DEPTH];
  logic [DW+1:0]  head;
  logic           aHs, mHs, push, fifoEmpty;

  // Credit decision depends only on the registered count, never on m_ready.
  assign a_ready   = !rst && (cnt_q < CntMax);
  assign aHs       = a_valid && a_ready;
  assign mem_cs    = aHs;
  assign mem_addr  = a_addr;

  assign push      = tagValid_q[LAT-1];
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign head      = fifoMem_q[rdPtr_q[PW-1:0]];
  assign m_valid   = !fifoEmpty;
  assign mHs       = m_valid && m_ready;
  assign m_data    = fifoEmpty ? '0 : head[DW+1:2];
  assign m_first   = !fifoEmpty && head[1];
  assign m_last    = !fifoEmpty && head[0];
  assign idle      = (cnt_q == '0);

  always_comb begin
    cnt_d   = cnt_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (aHs && !mHs) begin
      cnt_d = cnt_q + One;
    end else if (!aHs && mHs) begin
      cnt_d = cnt_q - One;
    end
    if (push) begin
      wrPtr_d = wrPtr_q + One;
    end
    if (mHs) begin
      rdPtr_d = rdPtr_q + One;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      tagValid_q <= '0;
      tagFirst_q <= '0;
      tagLast_q  <= '0;
    end else begin
      cnt_q         <= cnt_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      tagValid_q[0] <= aHs;
      tagFirst_q[0] <= a_first;
      tagLast_q[0]  <= a_last;
      for (int i = 1; i < LAT; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagFirst_q[i] <= tagFirst_q[i-1];
        tagLast_q[i]  <= tagLast_q[i-1];
      end
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q[PW-1:0]] <= {mem_rdata, tagFirst_q[LAT-1], tagLast_q[LAT-1]};
    end
  end

`ifdef DMA_RD_STAT_EN
  logic [15:0] beatCnt_q, frameCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beatCnt_q  <= '0;
      frameCnt_q <= '0;
    end else if (mHs) begin
      beatCnt_q <= beatCnt_q + 16'd1;
      if (m_last) begin
        frameCnt_q <= frameCnt_q + 16'd1;
      end
    end
  end

  assign beat_cnt  = beatCnt_q;
  assign frame_cnt = frameCnt_q;
`endif

endmodule

// File: tb/tb_dma_rd_stage.sv
// Scoreboard bench for dma_rd_stage: driver queues expected beats, a negedge monitor pops and compares.
module tb_dma_rd_stage;
  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] a_addr = '0;
  logic          a_first = 1'b0;
  logic          a_last = 1'b0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic          mem_cs;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] m_data;
  logic          m_first, m_last, m_valid;
  logic          m_ready = 1'b0;
  logic          idle;
`ifdef DMA_RD_STAT_EN
  logic [15:0]   beat_cnt, frame_cnt;
`endif

  dma_rd_stage #(.AW(AW), .DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_addr(a_addr), .a_first(a_first), .a_last(a_last), .a_valid(a_valid), .a_ready(a_ready),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_data(m_data), .m_first(m_first), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .idle(idle)
`ifdef DMA_RD_STAT_EN
    , .beat_cnt(beat_cnt), .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  int csCnt = 0;
  int outNow = 0;
  int outMax = 0;
  logic randOn = 1'b0;
  logic bpDone = 1'b0;
  logic [DW+1:0] expQ[$];
  int popCycQ[$];

  // SRAM contents: a fixed word at 0x0010, otherwise derived from the address.
  function automatic logic [DW-1:0] memVal(input logic [AW-1:0] a);
    if (a == 14'h0010) return 32'hDEADBEEF;
    return {4'hA, a, ~a};
  endfunction

  logic [DW-1:0] rdPipe [LAT];
  always @(posedge clk) begin
    rdPipe[0] <= mem_cs ? memVal(mem_addr) : 32'h0BADF00D;
    for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign mem_rdata = rdPipe[LAT-1];

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [DW+1:0] exp;
    popCycQ.push_back(cycleCnt);
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_beat: got 0x%0h expected no beat", {m_data, m_first, m_last});
    end else begin
      exp = expQ.pop_front();
      checkValue("beat", 64'({m_data, m_first, m_last}), 64'(exp));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      outNow = 0;
    end else begin
      if (mem_cs) begin
        csCnt++;
        outNow++;
      end
      if (m_valid && m_ready) begin
        outNow--;
        checkOutput();
      end
      if (outNow > outMax) outMax = outNow;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic f, input logic l);
    int waitCyc = 0;
    a_addr  = addr;
    a_first = f;
    a_last  = l;
    a_valid = 1'b1;
    @(negedge clk);
    while (!a_ready && waitCyc < 100) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!a_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL hs_timeout: got a_ready=0 expected 1 within 100 cycles");
    end else begin
      expQ.push_back({memVal(addr), f, l});
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    @(negedge clk);
    while (!(expQ.size() == 0 && idle) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkValue({name, "_idle"}, 64'(idle), 64'd1);
    checkValue({name, "_sb_empty"}, 64'(expQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int csBase;
    int n;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkValue("reset_a_ready_low", 64'(a_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkValue("reset_a_ready", 64'(a_ready), 64'd1);
    checkValue("reset_m_valid", 64'(m_valid), 64'd0);
    checkValue("reset_m_first", 64'(m_first), 64'd0);
    checkValue("reset_m_last", 64'(m_last), 64'd0);
    checkValue("reset_m_data", 64'(m_data), 64'd0);
    checkValue("reset_idle", 64'(idle), 64'd1);
    checkValue("reset_mem_cs", 64'(mem_cs), 64'd0);
`ifdef DMA_RD_STAT_EN
    checkValue("reset_beat_cnt", 64'(beat_cnt), 64'd0);
    checkValue("reset_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;

    $display("[TB] single beat");
    m_ready = 1'b1;
    applyStimulus(14'h0010, 1'b1, 1'b1);
    k = 1;
    @(negedge clk);
    while (!m_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkValue("single_latency", 64'(k), 64'(LAT + 1));
    waitDrain("single");

    $display("[TB] streaming 3x4 frame");
    popCycQ.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        applyStimulus(AW'(32'h0100 + r * 64 + c), (r == 0 && c == 0), (r == 2 && c == 3));
    waitDrain("stream");
    checkValue("stream_count", 64'(popCycQ.size()), 64'd12);
    if (popCycQ.size() == 12)
      checkValue("stream_span", 64'(popCycQ[11] - popCycQ[0]), 64'd11);

    $display("[TB] backpressure");
    m_ready = 1'b0;
    csBase = csCnt;
    bpDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyStimulus(AW'(32'h0200 + i * 3), i == 0, i == 5);
        bpDone = 1'b1;
      end
    join_none
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkValue("bp_cs_pulses", 64'(csCnt - csBase), 64'(DEPTH));
    checkValue("bp_a_ready_low", 64'(a_ready), 64'd0);
    checkValue("bp_m_valid", 64'(m_valid), 64'd1);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    checkValue("bp_a_ready_pop_cycle", 64'(a_ready), 64'd0);
    @(negedge clk);
    checkValue("bp_a_ready_rise", 64'(a_ready), 64'd1);
    n = 0;
    while (!bpDone && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkValue("bp_driver_done", 64'(bpDone), 64'd1);
    waitDrain("bp");
    checkValue("bp_cs_total", 64'(csCnt - csBase), 64'd6);

    $display("[TB] random m_ready");
    outMax = 0;
    randOn = 1'b1;
    fork
      begin
        while (randOn) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 200; i++)
      applyStimulus(AW'(i * 37 + 5), (i % 5) == 0, (i % 5) == 4);
    randOn = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    waitDrain("rand");
    checkValue("rand_outstanding_bound", 64'(outMax <= DEPTH), 64'd1);

    $display("[TB] reset with beats in flight");
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      applyStimulus(AW'(32'h0300 + i), i == 0, i == 2);
    rst = 1'b1;
    @(negedge clk);
    checkValue("rst_a_ready_low", 64'(a_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkValue("rst_m_valid", 64'(m_valid), 64'd0);
    checkValue("rst_idle", 64'(idle), 64'd1);
    checkValue("rst_a_ready", 64'(a_ready), 64'd1);
    checkValue("rst_m_data", 64'(m_data), 64'd0);
    repeat (LAT + 2) @(negedge clk);
    checkValue("rst_stale_ignored", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    applyStimulus(14'h0010, 1'b1, 1'b1);
    waitDrain("post_rst");

`ifdef DMA_RD_STAT_EN
    $display("[TB] statistics");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 6; b++)
        applyStimulus(AW'(32'h0400 + f * 16 + b), b == 0, b == 5);
    waitDrain("stat");
    checkValue("stat_beat_cnt", 64'(beat_cnt), 64'd12);
    checkValue("stat_frame_cnt", 64'(frame_cnt), 64'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_rd_stage.md
# dma_rd_stage

Memory read stage sitting directly downstream of the 2-D DMA address generator. It consumes the generator's address stream (addr/first/last with valid/ready) and issues one SRAM read per accepted address. It tags returning read data with the matching first/last flags and delivers it on a valid/ready data stream to the compute datapath. Credit-based reservation guarantees that no read data is ever dropped under downstream backpressure.

## Interface
- AW, 14, address width (matches generator)
- DW, 32, SRAM data width
- LAT, 1, SRAM read latency in cycles, legal 1..4
- DEPTH, 4, output FIFO entries, power of 2, must be ≥ LAT+2 for 1 beat/cycle
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- a_addr  in  AW  read address from generator
- a_first  in  1  first beat of a 2-D transfer
- a_last  in  1  last beat of a 2-D transfer
- a_valid  in  1  address valid
- a_ready  out  1  address accepted when a_valid & a_ready
- mem_cs  out  1  SRAM read strobe
- mem_addr  out  AW  SRAM read address
- mem_rdata  in  DW  SRAM read data, valid LAT cycles after mem_cs
- m_data  out  DW  read data
- m_first  out  1  tag copied from a_first
- m_last  out  1  tag copied from a_last
- m_valid  out  1  data valid
- m_ready  in  1  downstream accepts when m_valid & m_ready
- idle  out  1  no reservations outstanding

## Operation
- Reservation counter cnt, range 0..DEPTH, width clog2(DEPTH)+1: +1 on address handshake, −1 on output handshake, unchanged when both occur in the same cycle.
- a_ready = (cnt < DEPTH), registered-state only; no combinational path from m_ready.
- mem_cs = a_valid & a_ready; mem_addr = a_addr (combinational pass-through).
- Tag pipeline: LAT-stage shift register of {valid, first, last}, loaded on handshake. The stage-LAT output pushes {mem_rdata, first, last} into the FIFO.
- FIFO: DEPTH entries, wrap-around read/write pointers. A push can never find the FIFO full, because reservations cover every entry. Push and pop in the same cycle are both honoured.
- m_valid = FIFO not empty; m_data/m_first/m_last = head entry; head is held stable while m_valid & !m_ready.
- idle = (cnt == 0).
- Beat order is preserved exactly; first/last are carried through untouched and never interpreted.

## Timing
- Reset: a_ready=0 during the reset cycle, then 1. mem_cs=0, m_valid=0, m_first=0, m_last=0, m_data=0, idle=1, cnt=0, pointers=0, tag pipeline cleared.
- Reset mid-transfer: in-flight reads and buffered data are discarded; mem_rdata arriving after reset is ignored.
- Latency: address handshake in cycle t → m_valid in cycle t+LAT+1 (FIFO empty, m_ready high).
- Throughput: 1 beat/cycle sustained when DEPTH ≥ LAT+2 and m_ready is held high.
- Backpressure: with m_ready low, exactly DEPTH addresses are accepted, then a_ready drops. a_ready rises the cycle after the first output handshake.
- cnt==DEPTH with a simultaneous pop: a_ready stays 0 that cycle (registered decision).

## Configuration
- DMA_RD_STAT_EN defined: adds outputs beat_cnt[15:0] and frame_cnt[15:0], both reset to 0.
  - beat_cnt +1 per output handshake.
  - frame_cnt +1 per output handshake with m_last=1.
  - Both wrap 0xFFFF→0.
- DMA_RD_STAT_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Single beat, LAT=1: addr 0x0010 first=1 last=1, SRAM returns 0xDEADBEEF → m_valid 2 cycles after handshake, m_data=0xDEADBEEF, m_first=m_last=1, idle returns to 1.
- Streaming 3×4 frame, m_ready=1, LAT=2, DEPTH=4: 12 beats out on 12 consecutive cycles, data equals mem[addr], first only on beat 0, last only on beat 11.
- Backpressure: m_ready=0, continuous a_valid → exactly 4 mem_cs pulses, then a_ready=0. Release m_ready → remaining beats delivered in order with no loss or duplicate.
- Random m_ready (50%) over 1000 beats, LAT=3, DEPTH=8 → output sequence equals scoreboard; FIFO never overflows; cnt never exceeds 8.
- Reset asserted with 3 beats in flight → next cycle m_valid=0, idle=1. A fresh single-beat transfer completes with the correct data.
- With DMA_RD_STAT_EN: two frames of 6 beats → beat_cnt=12, frame_cnt=2.
